riscv_kgp_main_control: RTL and testbench
=========================================

Name: riscv_kgp_main_control

Overview:
- Multicycle main control FSM for the RISC_KGP core.
- Initiator side of the ALU-control interface: decodes the latched instruction and drives alu_op/func_code into the ALU control decoder.
- Also sequences instruction fetch, data-memory access with req/ack handshakes, register writeback and PC update.
- Sits between the instruction register, the memories and the datapath mux/enable controls.

Parameters:
- OPC_W, 6, opcode width (instr[31:26]).
- FUNC_W, 5, function-code width (instr[4:0]).
- TIMEOUT, 15, max cycles to wait for a memory ack before flagging bus_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from imem read data.
- imem_ack  in  1  instruction-memory data valid (one-cycle pulse).
- dmem_ack  in  1  data-memory done (one-cycle pulse).
- br_taken  in  1  branch condition from ALU flags, sampled in EXEC.
- imem_req  out  1  fetch request, held until ack.
- dmem_req  out  1  data access request, held until ack.
- dmem_we  out  1  1 = store, valid with dmem_req.
- ir_en  out  1  latch instr into IR.
- pc_en  out  1  PC update strobe.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- alu_op  out  2  0 = add (address), 1 = funct-driven, 2 = compare/subtract.
- func_code  out  5  registered instr[4:0], valid from DECODE onward.
- alu_src  out  1  0 = register, 1 = immediate.
- reg_we  out  1  register-file write strobe.
- mem_to_reg  out  1  writeback source: 1 = dmem data.
- halted  out  1  sticky, set by HALT opcode.
- bus_err  out  1  sticky, set on ack timeout or illegal opcode.

Behaviour:
- Reset, synchronous:
  - State goes to FETCH.
  - All outputs 0, including halted, bus_err, func_code and the timeout counter.
  - Reset mid-handshake drops the request in the same cycle.
- Opcode classes:
  - 0 ALU-R: alu_op = 1, alu_src = 0.
  - 1 ALU-I: alu_op = 1, alu_src = 1.
  - 2 LOAD, 3 STORE: alu_op = 0, alu_src = 1.
  - 4 BRANCH: alu_op = 2.
  - 5 JUMP, 6 HALT.
  - Any other opcode is illegal.
- Outputs are Moore-decoded from state plus the latched opcode and funct. The exception is ir_en, a one-cycle pulse in the cycle imem_ack is seen.
- FETCH: imem_req = 1. On imem_ack, pulse ir_en, latch opcode/funct, go to DECODE.
- DECODE, 1 cycle:
  - HALT: set halted, go to HALTED.
  - Illegal opcode: set bus_err, go to HALTED.
  - Otherwise go to EXEC.
- EXEC, 1 cycle:
  - alu_op/alu_src driven per class.
  - ALU-R/ALU-I: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_en = 1; pc_src = 1 if br_taken, else 0. Go to FETCH.
  - JUMP: pc_en = 1, pc_src = 2. Go to FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - alu_op held at 0 so the address stays stable.
  - On dmem_ack: LOAD goes to WB; STORE pulses pc_en (pc_src = 0) and goes to FETCH.
- WB, 1 cycle:
  - reg_we = 1; mem_to_reg = 1 for LOAD.
  - pc_en = 1, pc_src = 0.
  - Go to FETCH.
- HALTED: absorbing; all strobes and requests 0. Exit only by rst.
- Timeout:
  - A 4-bit counter clears on entry to FETCH/MEM and increments each cycle the request is held without ack.
  - When it reaches TIMEOUT, set bus_err, drop the request, go to HALTED.
  - An ack arriving in the same cycle the counter hits TIMEOUT wins: normal transition, no error.
- Ack handling:
  - An ack while its request is 0 is ignored.
  - imem_ack in MEM, or dmem_ack in FETCH, is ignored.
- CPI: 4 for ALU, 3 for branch/jump, 4 + wait for store, 5 + wait for load, each plus fetch wait.
- At most one pc_en per instruction. reg_we is never asserted in the same cycle as dmem_req.

Decomposition:
- Shared package riscv_kgp_pkg holds:
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - Opcode localparams OP_ALUR … OP_HALT.
  - ALU-op constants ALUOP_ADD = 0, ALUOP_FUNC = 1, ALUOP_CMP = 2.
  - PC_SRC constants.
- One natural sub-module: riscv_kgp_ack_timer, holding the timeout counter and its clear/expire logic.

Test Plan:
- ALU-R, opcode 0, funct 5'h03, imem_ack after 2 cycles:
  - ir_en pulses once.
  - EXEC shows alu_op = 1, func_code = 3, alu_src = 0.
  - WB shows reg_we = 1, pc_en = 1, pc_src = 0.
  - Back in FETCH 6 cycles after reset release.
- LOAD, dmem_ack after 3 MEM cycles:
  - dmem_req high for exactly 3 cycles with dmem_we = 0 and alu_op = 0.
  - Then WB with reg_we = 1, mem_to_reg = 1.
- BRANCH:
  - br_taken = 1: EXEC shows pc_en = 1, pc_src = 1, alu_op = 2, reg_we = 0.
  - Repeat with br_taken = 0: pc_src = 0.
- STORE with dmem_ack withheld:
  - After 15 request cycles, bus_err = 1 and dmem_req drops; state HALTED.
  - Variant with ack exactly at cycle 15: no error.
- HALT opcode 6: halted = 1 after DECODE, no further imem_req. Opcode 7: bus_err = 1.
- rst asserted during FETCH wait: imem_req = 0 next cycle. Stray dmem_ack in FETCH is ignored. After release, fetch restarts from a clean state.

Source files
------------

// File: rtl/riscv_kgp_pkg.sv
// Shared constants and types for the RISC_KGP multicycle control path.
package riscv_kgp_pkg;

  localparam int unsigned OPC_W  = 6;
  localparam int unsigned FUNC_W = 5;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned PCSRC_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALTED = 3'd5;

  localparam logic [OPC_W-1:0] OP_ALUR   = 6'd0;
  localparam logic [OPC_W-1:0] OP_ALUI   = 6'd1;
  localparam logic [OPC_W-1:0] OP_LOAD   = 6'd2;
  localparam logic [OPC_W-1:0] OP_STORE  = 6'd3;
  localparam logic [OPC_W-1:0] OP_BRANCH = 6'd4;
  localparam logic [OPC_W-1:0] OP_JUMP   = 6'd5;
  localparam logic [OPC_W-1:0] OP_HALT   = 6'd6;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_CMP  = 2'd2;

  localparam logic [PCSRC_W-1:0] PC_PLUS4  = 2'd0;
  localparam logic [PCSRC_W-1:0] PC_BRANCH = 2'd1;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'd2;

  // Datapath control bundle decoded once per cycle from the FSM state.
  typedef struct packed {
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic               pc_en;
    logic [PCSRC_W-1:0] pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_we;
    logic               mem_to_reg;
  } ctrl_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/riscv_kgp_ack_timer.sv
// Counts cycles a memory request waits for its ack and flags expiry.
module riscv_kgp_ack_timer
  import riscv_kgp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ack,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (active && !ack) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expires on the cycle the count would reach TIMEOUT; an ack that cycle wins.
  assign expire_c = active && !ack && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_kgp_main_control.sv
// Multicycle main control FSM: fetch, decode, execute, memory, writeback.
module riscv_kgp_main_control
  import riscv_kgp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               br_taken,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               ir_en,
  output logic               pc_en,
  output logic [PCSRC_W-1:0] pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [FUNC_W-1:0]  func_code,
  output logic               alu_src,
  output logic               reg_we,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               bus_err
);

  state_t           state;
  state_t           state_n;
  logic [OPC_W-1:0] opc_q;
  ctrl_t            ctrl;
  logic             ack_sel;
  logic             expire_c;
  logic             timer_clear;
  logic             unused_instr;

  assign unused_instr = ^instr[31-OPC_W:FUNC_W];

  // Only an ack matching the outstanding request counts.
  assign ack_sel     = (imem_req && imem_ack) || (dmem_req && dmem_ack);
  assign timer_clear = (state_n != state) && (state_n == ST_FETCH || state_n == ST_MEM);
  assign ir_en       = !rst && (state == ST_FETCH) && imem_ack;

  riscv_kgp_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .active   (imem_req || dmem_req),
    .ack      (ack_sel),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_FETCH: begin
        if (imem_ack) begin
          state_n = ST_DECODE;
        end else if (expire_c) begin
          state_n = ST_HALTED;
        end
      end
      ST_DECODE: begin
        if (opc_q == OP_HALT || !op_legal(opc_q)) begin
          state_n = ST_HALTED;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opc_q)
          OP_ALUR, OP_ALUI:  state_n = ST_WB;
          OP_LOAD, OP_STORE: state_n = ST_MEM;
          default:           state_n = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_n = (opc_q == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (expire_c) begin
          state_n = ST_HALTED;
        end
      end
      ST_WB:     state_n = ST_FETCH;
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_FETCH;
    endcase
  end

  // Instruction fields and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q     <= '0;
      func_code <= '0;
      halted    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (ir_en) begin
        opc_q     <= instr[31:32-OPC_W];
        func_code <= instr[FUNC_W-1:0];
      end
      if (state == ST_DECODE && opc_q == OP_HALT) begin
        halted <= 1'b1;
      end
      if ((state == ST_DECODE && !op_legal(opc_q)) || expire_c) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Moore decode; rst forces everything quiet so a pending request drops at once.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        ST_FETCH: ctrl.imem_req = 1'b1;
        ST_EXEC: begin
          case (opc_q)
            OP_ALUR: ctrl.alu_op = ALUOP_FUNC;
            OP_ALUI: begin
              ctrl.alu_op  = ALUOP_FUNC;
              ctrl.alu_src = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              ctrl.alu_op  = ALUOP_ADD;
              ctrl.alu_src = 1'b1;
            end
            OP_BRANCH: begin
              ctrl.alu_op = ALUOP_CMP;
              ctrl.pc_en  = 1'b1;
              ctrl.pc_src = br_taken ? PC_BRANCH : PC_PLUS4;
            end
            OP_JUMP: begin
              ctrl.pc_en  = 1'b1;
              ctrl.pc_src = PC_JUMP;
            end
            default: ctrl = '0;
          endcase
        end
        ST_MEM: begin
          ctrl.dmem_req = 1'b1;
          ctrl.dmem_we  = (opc_q == OP_STORE);
          ctrl.alu_op   = ALUOP_ADD;
          ctrl.alu_src  = 1'b1;
          ctrl.pc_en    = (opc_q == OP_STORE) && dmem_ack;
        end
        ST_WB: begin
          ctrl.reg_we     = 1'b1;
          ctrl.mem_to_reg = (opc_q == OP_LOAD);
          ctrl.pc_en      = 1'b1;
          ctrl.pc_src     = PC_PLUS4;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign imem_req   = ctrl.imem_req;
  assign dmem_req   = ctrl.dmem_req;
  assign dmem_we    = ctrl.dmem_we;
  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;
  assign alu_src    = ctrl.alu_src;
  assign reg_we     = ctrl.reg_we;
  assign mem_to_reg = ctrl.mem_to_reg;

endmodule

// File: tb/tb_riscv_kgp_main_control.sv
// Directed, table-driven bench for the RISC_KGP main control FSM.
module tb_riscv_kgp_main_control;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [4:0] func_code;
    logic       alu_src;
    logic       reg_we;
    logic       mem_to_reg;
    logic       halted;
    logic       bus_err;
  } out_t;

  // ctl = {rst, imem_ack, dmem_ack, br_taken}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] instr;
    out_t        want;
  } vec_t;

  localparam logic [31:0] I_ALUR = {6'd0, 21'h15A5A, 5'h03};
  localparam logic [31:0] I_ALUI = {6'd1, 21'h0F0F0, 5'h0A};
  localparam logic [31:0] I_LOAD = {6'd2, 21'h1FFFF, 5'h11};
  localparam logic [31:0] I_ST   = {6'd3, 21'h00001, 5'h04};
  localparam logic [31:0] I_BR   = {6'd4, 21'h12345, 5'h02};
  localparam logic [31:0] I_JMP  = {6'd5, 21'h0ABCD, 5'h1F};
  localparam logic [31:0] I_HALT = {6'd6, 21'h00000, 5'h01};
  localparam logic [31:0] I_ILL  = {6'd7, 21'h1AAAA, 5'h00};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ack, dmem_ack, br_taken;
  logic        imem_req, dmem_req, dmem_we, ir_en, pc_en;
  logic [1:0]  pc_src, alu_op;
  logic [4:0]  func_code;
  logic        alu_src, reg_we, mem_to_reg, halted, bus_err;

  int checks = 0;
  int passed = 0;
  vec_t tbl[$];

  riscv_kgp_main_control dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .func_code  (func_code),
    .alu_src    (alu_src),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [3:0] c, input logic [31:0] i, input out_t w);
    vec_t r;
    r.ctl   = c;
    r.instr = i;
    r.want  = w;
    return r;
  endfunction

  // One cycle: drive at negedge, compare 1ns later, well away from posedge.
  task automatic apply(input vec_t t, input string name);
    out_t got;
    @(negedge clk);
    {rst, imem_ack, dmem_ack, br_taken} = t.ctl;
    instr = t.instr;
    #1;
    got = {imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src, alu_op,
           func_code, alu_src, reg_we, mem_to_reg, halted, bus_err};
    checks++;
    if (got === t.want) passed++;
    else $display("FAIL %s: got %b required %b", name, got, t.want);
  endtask

  task automatic quiet_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic store_timeout(input logic ack_last);
    out_t w;
    quiet_reset();
    w = '0; w.imem_req = 1'b1; w.ir_en = 1'b1;
    apply(v(4'b0100, I_ST, w), "st_fetch");
    w = '0; w.func_code = 5'h04;
    apply(v(4'b0000, I_ST, w), "st_decode");
    w.alu_src = 1'b1;
    apply(v(4'b0000, I_ST, w), "st_exec");
    for (int k = 1; k <= 15; k++) begin
      w = '0; w.func_code = 5'h04;
      w.dmem_req = 1'b1; w.dmem_we = 1'b1; w.alu_src = 1'b1;
      w.pc_en = ack_last && (k == 15);
      apply(v({2'b00, ack_last && (k == 15), 1'b0}, I_ST, w), $sformatf("st_mem%0d_ack%0d", k, ack_last));
    end
    w = '0; w.func_code = 5'h04;
    if (ack_last) w.imem_req = 1'b1;
    else w.bus_err = 1'b1;
    apply(v(4'b0000, I_ST, w), $sformatf("st_after_ack%0d", ack_last));
  endtask

  task automatic fetch_timeout();
    out_t w;
    quiet_reset();
    for (int k = 1; k <= 15; k++) begin
      w = '0; w.imem_req = 1'b1;
      apply(v(4'b0000, I_ALUR, w), $sformatf("if_wait%0d", k));
    end
    w = '0; w.bus_err = 1'b1;
    apply(v(4'b0000, I_ALUR, w), "if_timeout");
    apply(v(4'b0100, I_ALUR, w), "if_halted_ack");
  endtask

  initial begin
    rst = 1'b1; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk);

    // out: IDWR_P_SS_AA_FFFFF_ARM_HB = {imem_req,dmem_req,dmem_we,ir_en}_pc_en_pc_src_alu_op_func_{alu_src,reg_we,mem_to_reg}_{halted,bus_err}
    tbl.push_back(v(4'b1000, I_ALUR, 19'b0000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_ALUR, 19'b1000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_ALUR, 19'b1000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0100, I_ALUR, 19'b1001_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_ALUR, 19'b0000_0_00_00_00011_000_00));
    tbl.push_back(v(4'b0000, I_ALUR, 19'b0000_0_00_01_00011_000_00));
    tbl.push_back(v(4'b0000, I_ALUR, 19'b0000_1_00_00_00011_010_00));
    tbl.push_back(v(4'b0100, I_LOAD, 19'b1001_0_00_00_00011_000_00));
    tbl.push_back(v(4'b0000, I_LOAD, 19'b0000_0_00_00_10001_000_00));
    tbl.push_back(v(4'b0000, I_LOAD, 19'b0000_0_00_00_10001_100_00));
    tbl.push_back(v(4'b0000, I_LOAD, 19'b0100_0_00_00_10001_100_00));
    tbl.push_back(v(4'b0100, I_LOAD, 19'b0100_0_00_00_10001_100_00));
    tbl.push_back(v(4'b0010, I_LOAD, 19'b0100_0_00_00_10001_100_00));
    tbl.push_back(v(4'b0000, I_LOAD, 19'b0000_1_00_00_10001_011_00));
    tbl.push_back(v(4'b0010, I_LOAD, 19'b1000_0_00_00_10001_000_00));
    tbl.push_back(v(4'b0100, I_BR,   19'b1001_0_00_00_10001_000_00));
    tbl.push_back(v(4'b0000, I_BR,   19'b0000_0_00_00_00010_000_00));
    tbl.push_back(v(4'b0001, I_BR,   19'b0000_1_01_10_00010_000_00));
    tbl.push_back(v(4'b0100, I_BR,   19'b1001_0_00_00_00010_000_00));
    tbl.push_back(v(4'b0001, I_BR,   19'b0000_0_00_00_00010_000_00));
    tbl.push_back(v(4'b0000, I_BR,   19'b0000_1_00_10_00010_000_00));
    tbl.push_back(v(4'b0100, I_JMP,  19'b1001_0_00_00_00010_000_00));
    tbl.push_back(v(4'b0000, I_JMP,  19'b0000_0_00_00_11111_000_00));
    tbl.push_back(v(4'b0001, I_JMP,  19'b0000_1_10_00_11111_000_00));
    tbl.push_back(v(4'b0100, I_ALUI, 19'b1001_0_00_00_11111_000_00));
    tbl.push_back(v(4'b0000, I_ALUI, 19'b0000_0_00_00_01010_000_00));
    tbl.push_back(v(4'b0000, I_ALUI, 19'b0000_0_00_01_01010_100_00));
    tbl.push_back(v(4'b0000, I_ALUI, 19'b0000_1_00_00_01010_010_00));
    tbl.push_back(v(4'b0100, I_ST,   19'b1001_0_00_00_01010_000_00));
    tbl.push_back(v(4'b0000, I_ST,   19'b0000_0_00_00_00100_000_00));
    tbl.push_back(v(4'b0000, I_ST,   19'b0000_0_00_00_00100_100_00));
    tbl.push_back(v(4'b0010, I_ST,   19'b0110_1_00_00_00100_100_00));
    tbl.push_back(v(4'b0000, I_ST,   19'b1000_0_00_00_00100_000_00));
    tbl.push_back(v(4'b1000, I_ST,   19'b0000_0_00_00_00100_000_00));
    tbl.push_back(v(4'b1000, I_ST,   19'b0000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0010, I_ST,   19'b1000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0100, I_HALT, 19'b1001_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_HALT, 19'b0000_0_00_00_00001_000_00));
    tbl.push_back(v(4'b0100, I_HALT, 19'b0000_0_00_00_00001_000_10));
    tbl.push_back(v(4'b0110, I_HALT, 19'b0000_0_00_00_00001_000_10));
    tbl.push_back(v(4'b1000, I_ILL,  19'b0000_0_00_00_00001_000_10));
    tbl.push_back(v(4'b1000, I_ILL,  19'b0000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0100, I_ILL,  19'b1001_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_ILL,  19'b0000_0_00_00_00000_000_00));
    tbl.push_back(v(4'b0000, I_ILL,  19'b0000_0_00_00_00000_000_01));
    tbl.push_back(v(4'b0100, I_ILL,  19'b0000_0_00_00_00000_000_01));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    store_timeout(1'b0);
    store_timeout(1'b1);
    fetch_timeout();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
